// File: rtl/scene_table_ctrl.sv
// scene_table_ctrl
//   Double-buffered sphere table between the SPI receiver and the line
//   controller. A header word (magic 0xA5 in the top byte, sphere count in
//   the low CNT_W bits) is followed by that many sphere words, which are
//   collected into a shadow bank. The complete scene is copied into the
//   active bank in one cycle, at a frame boundary, once the renderer is idle.
//
// Ports
//   CLK100MHZ       in   system clock, rising edge
//   ck_rst          in   synchronous active-high reset
//   recv_dv         in   strobe, recv_64bit valid
//   recv_64bit      in   received header or sphere word
//   recv_interrupt  out  high = ready to accept SPI words
//   frame_start     in   pulse at the start of each frame
//   line_busy       in   high while the line controller is working
//   spheres         out  active bank, slot k at [k*SPHERE_W +: SPHERE_W]
//   sphere_count    out  valid slots in the active bank
//   swap_done       out  pulse coincident with the active-bank update
//   load_err        out  sticky protocol error, cleared only by reset
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a header word
// LOAD     | collecting C sphere words into the shadow bank
// PENDING  | scene complete, waiting for frame_start and an idle renderer
// SWAP     | one cycle: shadow bank copied into the active bank

module scene_table_ctrl #(
  parameter int MAX_SPHERES = 8,
  parameter int SPHERE_W    = 64,
  parameter int CNT_W       = 4
) (
  input  logic                            CLK100MHZ,
  input  logic                            ck_rst,
  input  logic                            recv_dv,
  input  logic [SPHERE_W-1:0]             recv_64bit,
  output logic                            recv_interrupt,
  input  logic                            frame_start,
  input  logic                            line_busy,
  output logic [MAX_SPHERES*SPHERE_W-1:0] spheres,
  output logic [CNT_W-1:0]                sphere_count,
  output logic                            swap_done,
  output logic                            load_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;
  localparam logic [1:0] S_SWAP    = 2'd3;

  localparam logic [7:0]       MAGIC   = 8'hA5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SPHERES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] act_count_q;
  logic             frame_seen_q, frame_seen_d;
  logic             load_err_q, load_err_d;
  logic             irq_q;
  logic             swap_done_q;

  logic [MAX_SPHERES-1:0][SPHERE_W-1:0] shadow_q;
  logic [MAX_SPHERES-1:0][SPHERE_W-1:0] active_q;

  logic [CNT_W-1:0] hdr_count;
  logic             hdr_ok;
  logic             shadow_we;

  assign hdr_count = recv_64bit[CNT_W-1:0];
  assign hdr_ok    = (recv_64bit[SPHERE_W-1 -: 8] == MAGIC) &&
                     (hdr_count != '0) && (hdr_count <= MAX_CNT);
  assign shadow_we = (state_q == S_LOAD) && recv_dv;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    frame_seen_d = frame_seen_q;
    load_err_d   = load_err_q;
    case (state_q)
      S_IDLE: begin
        if (recv_dv) begin
          if (hdr_ok) begin
            count_d = hdr_count;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (recv_dv) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == count_q - 1'b1) state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (recv_dv) load_err_d = 1'b1;
        // Only a frame_start seen while already pending arms the swap.
        if (frame_start) frame_seen_d = 1'b1;
        if (frame_seen_q && !line_busy) state_d = S_SWAP;
      end
      default: begin
        if (recv_dv) load_err_d = 1'b1;
        frame_seen_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      frame_seen_q <= 1'b0;
      load_err_q   <= 1'b0;
      irq_q        <= 1'b0;
      swap_done_q  <= 1'b0;
      act_count_q  <= '0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      frame_seen_q <= frame_seen_d;
      load_err_q   <= load_err_d;
      // Registered from the current state, so it lags the state by one edge.
      irq_q        <= (state_q == S_IDLE) || (state_q == S_LOAD);
      swap_done_q  <= (state_q == S_SWAP);
      if (state_q == S_SWAP) begin
        act_count_q <= count_q;
        for (int k = 0; k < MAX_SPHERES; k++) begin
          active_q[k] <= (k < int'(count_q)) ? shadow_q[k] : '0;
        end
      end
    end
  end

  // Shadow contents are only meaningful between header and swap, so no reset.
  always_ff @(posedge CLK100MHZ) begin
    if (shadow_we) begin
      for (int k = 0; k < MAX_SPHERES; k++) begin
        if (idx_q == CNT_W'(k)) shadow_q[k] <= recv_64bit;
      end
    end
  end

  assign spheres        = active_q;
  assign sphere_count   = act_count_q;
  assign swap_done      = swap_done_q;
  assign load_err       = load_err_q;
  assign recv_interrupt = irq_q;

endmodule

// File: doc/scene_table_ctrl.md
# scene_table_ctrl

Double-buffered sphere-table controller between the SPI receiver and the raytracing line controller. Collects a header plus N 64-bit sphere words from the SPI link into a shadow bank while the renderer keeps reading a stable active bank. At a frame boundary, when the renderer is idle, it swaps the complete scene in atomically. This replaces the single `recv_64bit` sphere register, so a scene can never change mid-frame or mid-line.

## Interface
Parameters:
- MAX_SPHERES, 8: sphere slots per bank, range 1..15.
- SPHERE_W, 64: bits per packed `Types::Sphere` word.
- CNT_W, 4: width of the sphere count; must hold MAX_SPHERES.

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- ck_rst  in  1  reset; synchronous, active-high.
- recv_dv  in  1  one-cycle strobe; `recv_64bit` is valid.
- recv_64bit  in  SPHERE_W  received word.
- recv_interrupt  out  1  high = ready for SPI words (flow control to MCU).
- frame_start  in  1  one-cycle pulse at the start of each frame (line 0 requested).
- line_busy  in  1  high while the line controller is in setup or rendering.
- spheres  out  MAX_SPHERES*SPHERE_W  active bank; slot k occupies bits [k*SPHERE_W +: SPHERE_W].
- sphere_count  out  CNT_W  number of valid slots in the active bank.
- swap_done  out  1  one-cycle pulse, coincident with the active-bank update.
- load_err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- State `IDLE`: waits for a header word.
  - A valid header has `recv_64bit[63:56] == 8'hA5` and count `C = recv_64bit[CNT_W-1:0]` with 1 ≤ C ≤ MAX_SPHERES.
  - Valid header: latch C, clear the write index, go to `LOAD`.
  - Invalid header: drop the word, set `load_err`, stay in `IDLE`.
- State `LOAD`: each `recv_dv` writes `shadow[idx]` and increments `idx`.
  - The word with `idx == C-1` moves the FSM to `PENDING`.
  - Data words are not checked for the magic byte.
- State `PENDING`: `recv_interrupt` is low.
  - Any `recv_dv` is dropped and sets `load_err`.
  - `frame_start` sets a `frame_seen` latch. The latch is set only while in `PENDING`, so a `frame_start` in the same cycle as the final data word does not count.
  - When `frame_seen && !line_busy`, go to `SWAP`.
- State `SWAP` (one cycle):
  - Active slot k takes `shadow[k]` for k < C and zero for k ≥ C.
  - `sphere_count` takes C.
  - `swap_done` pulses; `frame_seen` clears; next state is `IDLE`.
- `recv_interrupt`: registered; high in `IDLE` and `LOAD`, low in `PENDING` and `SWAP`.
- Shadow bank contents outside a load are don't-care and never visible on the outputs.
- The active bank is written only in `SWAP`. The output is stable across all of `IDLE`, `LOAD` and `PENDING`.

## Timing
- Reset values (on the edge where `ck_rst` is sampled high):
  - State `IDLE`; `spheres` all zero; `sphere_count` 0.
  - `recv_interrupt` 0; `swap_done` 0; `load_err` 0; `frame_seen` 0; `idx` 0.
- `recv_interrupt` rises on the first edge after reset deasserts.
- Reset mid-load or in `PENDING`: the partial or staged scene is discarded and the active bank is zeroed.
- Final data word sampled at edge t: state is `PENDING` and `recv_interrupt` is 0 after edge t+1.
- `frame_start` sampled in `PENDING` at edge f with `line_busy` low:
  - `SWAP` after edge f+1.
  - `spheres`, `sphere_count` and `swap_done` all update after edge f+2.
  - `recv_interrupt` is 1 again after edge f+3.
- `line_busy` high when `frame_seen` is set: the swap is deferred; `SWAP` is entered on the edge after `line_busy` is sampled low. It does not wait for another `frame_start`.
- `recv_dv` back-to-back on every cycle is accepted in `IDLE` and `LOAD`; no minimum gap.
- `recv_dv` in `SWAP` is dropped and sets `load_err`.
- `frame_start` and `recv_dv` in the same cycle are processed independently according to the current state.

## Test plan
- Reset, then header `0xA5000000_00000002` followed by words W0 = `0x...0001`, W1 = `0x...0002`, then a `frame_start` pulse with `line_busy` = 0 -> slots 0/1 = W0/W1, slots 2..7 = 0, `sphere_count` = 2, single `swap_done` pulse exactly 2 cycles after `frame_start`.
- Headers with count 0, count 9, and magic `0xA4` -> `load_err` = 1, FSM stays `IDLE`; a following valid 1-sphere load completes normally with `load_err` still 1.
- Complete a load, hold `line_busy` = 1, pulse `frame_start`, release `line_busy` 20 cycles later -> no output change while busy; swap lands 2 cycles after release.
- `frame_start` coincident with the final data word, second `frame_start` 100 cycles later -> no swap on the first pulse; swap follows the second.
- Extra `recv_dv` in `PENDING` -> word dropped, `load_err` = 1, active bank unchanged; `recv_interrupt` is 0 throughout `PENDING`.
- `ck_rst` asserted after 3 of 5 data words -> all outputs at reset values; a subsequent 5-word load behaves as from cold.
